// File: rtl/uart_tx_feeder_if.sv
// WISHBONE-style word bus between the transmit feeder (master) and the MiniUART (slave).
interface uart_tx_feeder_if;
  logic [2:0]  ADD_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I;

  modport master (output ADD_O, DAT_O, STB_O, WE_O, input DAT_I, ACK_I);
  modport slave  (input ADD_O, DAT_O, STB_O, WE_O, output DAT_I, ACK_I);
endinterface

// File: rtl/uart_tx_feeder.sv
// Transmit byte FIFO plus a bus master that drains it into the MiniUART DATA register.
// Optional drain-complete interrupt (irq/irq_ack) when UART_TXF_IRQ_EN is defined.
module uart_tx_feeder #(
  parameter int         DEPTH     = 16,
  parameter int         AW        = $clog2(DEPTH),
  parameter logic [2:0] OFF_DATA  = 3'b000,
  parameter logic [2:0] OFF_LSR   = 3'b001,
  parameter int         TS_BIT    = 5,
  parameter int         GUARD_CYC = 4
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          push,
  input  logic [7:0]    push_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  input  logic          ovf_clr,
`ifdef UART_TXF_IRQ_EN
  output logic          irq,
  input  logic          irq_ack,
`endif
  uart_tx_feeder_if.master wb
);

  typedef enum logic [1:0] {IDLE, POLL, WRITE, GUARD} state_t;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        ovf_q;
  state_t      state_q;
  state_t      state_d;
  logic [7:0]  gcnt_q;
  logic [7:0]  gcnt_d;
  logic        pop;
  logic        push_ok;
  logic [7:0]  head;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
  assign ovf   = ovf_q;
  assign head  = mem[rp[AW-1:0]];

  // A same-cycle pop frees the slot the push is about to overwrite.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge CLK_I) begin
    if (push_ok) begin
      mem[wp[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wp    <= '0;
      rp    <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      if (ovf_clr)
        ovf_q <= 1'b0;
      else if (push && !push_ok)
        ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Write strobe lasts one cycle: WRITE always leaves on the combinational ACK.
  always_comb begin
    state_d  = state_q;
    gcnt_d   = gcnt_q;
    pop      = 1'b0;
    wb.STB_O = 1'b0;
    wb.WE_O  = 1'b0;
    wb.ADD_O = 3'b000;
    wb.DAT_O = 32'h0;
    case (state_q)
      IDLE: begin
        if (!empty) state_d = POLL;
      end
      POLL: begin
        wb.STB_O = 1'b1;
        wb.ADD_O = OFF_LSR;
        if (wb.ACK_I && wb.DAT_I[TS_BIT]) state_d = WRITE;
      end
      WRITE: begin
        wb.STB_O = 1'b1;
        wb.WE_O  = 1'b1;
        wb.ADD_O = OFF_DATA;
        wb.DAT_O = {24'h0, head};
        if (wb.ACK_I) begin
          pop     = 1'b1;
          gcnt_d  = 8'(GUARD_CYC - 1);
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (gcnt_q == 8'd0)
          state_d = IDLE;
        else
          gcnt_d = gcnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_TXF_IRQ_EN
  logic irq_q;
  assign irq = irq_q;

  always_ff @(posedge CLK_I) begin
    if (RST_I)
      irq_q <= 1'b0;
    else if (irq_ack)
      irq_q <= 1'b0;
    else if (state_q == GUARD && gcnt_q == 8'd0 && empty)
      irq_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: vector table for the basic push/poll/write timing plus
// hand sequences for stalled polling, overflow, full push+pop, mid-write reset and optional irq.
module tb_uart_tx_feeder;
  logic       CLK_I;
  logic       RST_I;
  logic       push;
  logic [7:0] push_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       ovf;
  logic       ovf_clr;
  logic       ts;
`ifdef UART_TXF_IRQ_EN
  logic       irq;
  logic       irq_ack;
`endif

  int tests = 0;
  int fails = 0;

  uart_tx_feeder_if bus ();

  // UART model: ACK tied to STB, LSR ts bit at position 5.
  assign bus.ACK_I = bus.STB_O;
  assign bus.DAT_I = {26'h0, ts, 5'h0};

  uart_tx_feeder dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .push      (push),
    .push_data (push_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
`ifdef UART_TXF_IRQ_EN
    .irq       (irq),
    .irq_ack   (irq_ack),
`endif
    .wb        (bus)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  logic [7:0] wq[$];
  int nwr  = 0;
  int npol = 0;
  int b2b  = 0;
  logic prev_wr = 1'b0;

  always @(negedge CLK_I) begin
    if (!RST_I) begin
      if (bus.STB_O && bus.ACK_I && bus.WE_O) begin
        wq.push_back(bus.DAT_O[7:0]);
        nwr <= nwr + 1;
        if (prev_wr) b2b <= b2b + 1;
      end
      if (bus.STB_O && bus.ACK_I && !bus.WE_O) npol <= npol + 1;
    end
    prev_wr <= bus.STB_O && bus.WE_O;
  end

  typedef struct {
    logic        push;
    logic [7:0]  data;
    logic        ts;
    logic        stb;
    logic        we;
    logic [2:0]  add;
    logic [31:0] dat;
    logic [4:0]  cnt;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(logic p, logic [7:0] d, logic t, logic s, logic w,
                              logic [2:0] a, logic [31:0] dt, logic [4:0] c);
    vec_t v;
    v.push = p; v.data = d; v.ts = t; v.stb = s; v.we = w; v.add = a; v.dat = dt; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic do_reset();
    RST_I = 1'b1;
    push = 1'b0;
    ovf_clr = 1'b0;
    tick();
    tick();
    RST_I = 1'b0;
  endtask

  task automatic wait_write(input string nm, output logic found);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.STB_O && bus.WE_O) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) chk(nm, 64'd0, 64'd1);
  endtask

  initial begin
    logic found;
    int   base_w;
    int   base_p;
    int   pc;
    int   wc;
    logic order_ok;

    RST_I = 1'b1; push = 1'b0; push_data = 8'h0; ovf_clr = 1'b0; ts = 1'b1;
`ifdef UART_TXF_IRQ_EN
    irq_ack = 1'b0;
`endif

    vt[0]  = mk(1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        5'd1);
    vt[1]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 32'h0,        5'd1);
    vt[2]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 32'h00000041, 5'd1);
    vt[3]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        5'd0);
    vt[4]  = mk(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        5'd1);
    vt[5]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        5'd1);
    vt[6]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        5'd1);
    vt[7]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        5'd1);
    vt[8]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 32'h0,        5'd1);
    vt[9]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 32'h0,        5'd1);
    vt[10] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 32'h0,        5'd1);
    vt[11] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 32'h0000005A, 5'd1);
    vt[12] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        5'd0);
    vt[13] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        5'd0);

    // Reset state
    do_reset();
    chk("reset_flags", {60'h0, empty, full, ovf, 1'b0}, {60'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_bus", {26'h0, bus.STB_O, bus.WE_O, bus.ADD_O, bus.DAT_O}, 64'h0);

    // Vector table: latency, single-cycle strobe, guard spacing, re-poll on ts=0
    for (int i = 0; i < 14; i++) begin
      push = vt[i].push;
      push_data = vt[i].data;
      ts = vt[i].ts;
      tick();
      chk($sformatf("vec%0d", i),
          {22'h0, bus.STB_O, bus.WE_O, bus.ADD_O, bus.DAT_O, count},
          {22'h0, vt[i].stb, vt[i].we, vt[i].add, vt[i].dat, vt[i].cnt});
    end
    push = 1'b0;
    chk("vec_empty_after", 64'(empty), 64'd1);

    // ts held low for 20 cycles: only polls, then a write right after ts rises
    do_reset();
    ts = 1'b0;
    push = 1'b1; push_data = 8'h33;
    tick();
    push = 1'b0;
    pc = 0; wc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.STB_O && !bus.WE_O && bus.ADD_O == 3'd1) pc++;
      if (bus.STB_O && bus.WE_O) wc++;
    end
    chk("stall_polls", 64'(pc), 64'd20);
    chk("stall_writes", 64'(wc), 64'd0);
    ts = 1'b1;
    tick();
    chk("stall_release_write", {31'h0, bus.STB_O, bus.WE_O, bus.DAT_O},
        {31'h0, 1'b1, 1'b1, 32'h00000033});
    for (int i = 0; i < 10; i++) tick();
    chk("stall_empty_after", 64'(empty), 64'd1);

    // Overflow with the engine stalled, then push during the WRITE pop while full
    do_reset();
    ts = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      push = 1'b1; push_data = 8'(k);
      tick();
    end
    push = 1'b0;
    chk("ovf_full", {61'h0, full, empty, ovf}, {61'h0, 1'b1, 1'b0, 1'b1});
    chk("ovf_count", 64'(count), 64'd16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(ovf), 64'd0);
    base_w = nwr;
    ts = 1'b1;
    wait_write("full_wait_write", found);
    if (found) begin
      push = 1'b1; push_data = 8'hEE;
      tick();
      push = 1'b0;
      chk("full_pushpop_count", 64'(count), 64'd16);
      chk("full_pushpop_ovf", {62'h0, ovf, full}, {62'h0, 1'b0, 1'b1});
    end
    for (int i = 0; i < 500 && (nwr - base_w) < 17; i++) tick();
    for (int i = 0; i < 30; i++) tick();
    chk("drain_nbytes", 64'(nwr - base_w), 64'd17);
    order_ok = 1'b1;
    if ((nwr - base_w) >= 17) begin
      for (int k = 0; k < 16; k++)
        if (wq[base_w + k] != 8'(k + 1)) order_ok = 1'b0;
      chk("drain_last_byte", 64'(wq[base_w + 16]), 64'hEE);
    end else begin
      order_ok = 1'b0;
    end
    chk("drain_order", 64'(order_ok), 64'd1);
    chk("drain_empty", 64'(empty), 64'd1);
    chk("no_back_to_back", 64'(b2b), 64'd0);

    // Reset asserted during a WRITE with 5 bytes queued
    do_reset();
    ts = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push = 1'b1; push_data = 8'(8'hA0 + k);
      tick();
    end
    push = 1'b0;
    ts = 1'b1;
    wait_write("rst_wait_write", found);
    RST_I = 1'b1;
    tick();
    chk("rst_mid_stb", 64'(bus.STB_O), 64'd0);
    chk("rst_mid_fifo", {58'h0, count, empty}, {58'h0, 5'd0, 1'b1});
    RST_I = 1'b0;
    base_w = nwr;
    base_p = npol;
    for (int i = 0; i < 30; i++) tick();
    chk("rst_mid_quiet", {32'(nwr - base_w), 32'(npol - base_p)}, 64'h0);

`ifdef UART_TXF_IRQ_EN
    // Drain-complete interrupt
    do_reset();
    ts = 1'b1;
    chk("irq_reset", 64'(irq), 64'd0);
    base_w = nwr;
    for (int k = 0; k < 3; k++) begin
      push = 1'b1; push_data = 8'(8'h10 + k);
      tick();
    end
    push = 1'b0;
    found = 1'b0;
    wc = -1;
    pc = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (bus.STB_O && bus.WE_O) wc = i;
      if (irq) begin
        found = 1'b1;
        pc = i;
        break;
      end
    end
    chk("irq_seen", 64'(found), 64'd1);
    chk("irq_writes", 64'(nwr - base_w), 64'd3);
    chk("irq_timing", 64'(pc - wc), 64'd5);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("irq_ack", 64'(irq), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
